// File: rtl/ram_sync.sv
// ram_sync: parameterised single-port synchronous RAM with a registered read
// port, a hardware clear sequencer and out-of-range address detection.
// A clear runs after every reset and on request. While it runs, busy is high
// and read/write/clear requests are ignored.
module ram_sync #(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 12,
  parameter int                DEPTH     = 4096,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              addr_err
);

  // Index width into the storage array. It never exceeds ADDR_W because
  // DEPTH <= 2**ADDR_W.
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH = 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_go;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wd;

  // Decode the access: range check on the full address, then a narrow index.
  always_comb begin
    in_range = {1'b0, addr} < DEPTH_V;
    acc_idx  = addr[IDX_W-1:0];
    // A request is only acted on in READY when no clear is requested.
    acc_go   = (state == READY) && !clear;
  end

  // Single write port, shared by the clear sequencer and user writes.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = acc_idx;
    mem_wd  = in;
    if (rst_n) begin
      if (state == CLEAR) begin
        mem_we  = 1'b1;
        mem_idx = clr_ptr[IDX_W-1:0];
        mem_wd  = CLEAR_VAL;
      end else if (acc_go && write && in_range) begin
        mem_we  = 1'b1;
      end
    end
  end

  // Storage array: no reset; contents are defined only by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // Control FSM with registered read data, strobes and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          out       <= '0;
          out_valid <= 1'b0;
          addr_err  <= 1'b0;
          // Exit on the edge that writes the last word; the pointer is back
          // at 0 ready for the next clear.
          if (clr_ptr == LAST) begin
            clr_ptr <= '0;
            state   <= READY;
            busy    <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        READY: begin
          if (clear) begin
            // Clear wins; any same-cycle read or write is dropped.
            state     <= CLEAR;
            busy      <= 1'b1;
            clr_ptr   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
          end else begin
            out_valid <= read;
            addr_err  <= (read || write) && !in_range;
            // Memory read sees the pre-write contents (read-before-write).
            if (read && in_range) out <= mem[acc_idx];
            else                  out <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: two instances (DEPTH=12 and DEPTH=16) driven by the same
// stimulus, each compared every cycle against a behavioural model, plus
// literal expectations for the directed scenarios.
module tb_ram_sync;

  localparam logic [3:0] CV = 4'hA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0] addr = '0, din = '0;

  logic [3:0] dout  [2];
  logic       dval  [2];
  logic       dbusy [2];
  logic       derr  [2];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_sync #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .CLEAR_VAL(CV)) u_d12 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .read(read), .write(write),
    .addr(addr), .in(din), .out(dout[0]), .out_valid(dval[0]),
    .busy(dbusy[0]), .addr_err(derr[0]));

  ram_sync #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .CLEAR_VAL(CV)) u_d16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .read(read), .write(write),
    .addr(addr), .in(din), .out(dout[1]), .out_valid(dval[1]),
    .busy(dbusy[1]), .addr_err(derr[1]));

  // ---------------- behavioural model ----------------
  int         depth [2] = '{12, 16};
  int         clr_left [2] = '{12, 16};
  logic [3:0] mm [2][16];
  logic [3:0] eo [2] = '{4'h0, 4'h0};
  logic       ev [2] = '{1'b0, 1'b0};
  logic       eb [2] = '{1'b1, 1'b1};
  logic       ee [2] = '{1'b0, 1'b0};

  // A clear is a countdown; when it completes every word holds CV.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        clr_left[k] = depth[k];
        eo[k] = 4'h0; ev[k] = 1'b0; ee[k] = 1'b0; eb[k] = 1'b1;
      end else if (clr_left[k] > 0) begin
        clr_left[k] = clr_left[k] - 1;
        eo[k] = 4'h0; ev[k] = 1'b0; ee[k] = 1'b0;
        if (clr_left[k] == 0) begin
          for (int a = 0; a < 16; a++) mm[k][a] = CV;
          eb[k] = 1'b0;
        end
      end else if (clear) begin
        clr_left[k] = depth[k];
        eo[k] = 4'h0; ev[k] = 1'b0; ee[k] = 1'b0; eb[k] = 1'b1;
      end else begin
        ev[k] = read;
        ee[k] = (read || write) && (int'(addr) >= depth[k]);
        eo[k] = (read && int'(addr) < depth[k]) ? mm[k][addr] : 4'h0;
        if (write && int'(addr) < depth[k]) mm[k][addr] = din;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy[%0d]", k),  32'(dbusy[k]), 32'(eb[k]));
      chk($sformatf("out[%0d]", k),   32'(dout[k]),  32'(eo[k]));
      chk($sformatf("valid[%0d]", k), 32'(dval[k]),  32'(ev[k]));
      chk($sformatf("err[%0d]", k),   32'(derr[k]),  32'(ee[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic c, input logic r, input logic w,
                      input logic [3:0] a, input logic [3:0] d);
    clear = c; read = r; write = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle steps until each instance drops busy; -1 marks an expired bound.
  task automatic measure(output int n0, output int n1);
    n0 = -1; n1 = -1;
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 0, 4'h0, 4'h0);
      if (n0 < 0 && !dbusy[0]) n0 = i;
      if (n1 < 0 && !dbusy[1]) n1 = i;
      if (n0 >= 0 && n1 >= 0) break;
    end
  endtask

  initial begin
    int n0, n1;
    // 1. reset release
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 4'h0);
    chk("rst_busy", 32'(dbusy[0]), 32'd1);
    chk("rst_out", 32'(dout[0]), 32'd0);
    rst_n = 1'b1;
    measure(n0, n1);
    chk("rel_cycles12", 32'(n0), 32'd12);
    chk("rel_cycles16", 32'(n1), 32'd16);
    for (int a = 0; a < 12; a++) begin
      step(0, 1, 0, 4'(a), 4'h0);
      chk("init_rd", 32'(dout[0]), 32'hA);
      chk("init_vld", 32'(dval[0]), 32'd1);
    end
    // 2. write/read latency
    step(0, 0, 1, 4'd3, 4'h5);
    step(0, 1, 0, 4'd3, 4'h0);
    chk("lat_out", 32'(dout[0]), 32'h5);
    chk("lat_vld", 32'(dval[0]), 32'd1);
    step(0, 0, 0, 4'd0, 4'h0);
    chk("idle_out", 32'(dout[0]), 32'h0);
    chk("idle_vld", 32'(dval[0]), 32'd0);
    // 3. simultaneous read+write
    step(0, 0, 1, 4'd7, 4'h2);
    step(0, 1, 1, 4'd7, 4'h9);
    chk("rw_old", 32'(dout[0]), 32'h2);
    step(0, 1, 0, 4'd7, 4'h0);
    chk("rw_new", 32'(dout[0]), 32'h9);
    // 4. out of range
    step(0, 0, 1, 4'd13, 4'hF);
    chk("oor_wr_err", 32'(derr[0]), 32'd1);
    chk("oor_wr_err16", 32'(derr[1]), 32'd0);
    step(0, 1, 0, 4'd13, 4'h0);
    chk("oor_rd_err", 32'(derr[0]), 32'd1);
    chk("oor_rd_out", 32'(dout[0]), 32'h0);
    chk("oor_rd_vld", 32'(dval[0]), 32'd1);
    chk("oor_rd16", 32'(dout[1]), 32'hF);
    step(0, 1, 0, 4'd1, 4'h0);
    chk("alias_rd", 32'(dout[0]), 32'hA);
    chk("alias_err", 32'(derr[0]), 32'd0);
    // 5. clear with colliding write
    step(0, 0, 1, 4'd0, 4'h7);
    step(1, 0, 1, 4'd0, 4'h3);
    measure(n0, n1);
    chk("clr_cycles12", 32'(n0), 32'd12);
    chk("clr_cycles16", 32'(n1), 32'd16);
    for (int a = 0; a < 12; a++) begin
      step(0, 1, 0, 4'(a), 4'h0);
      chk("clr_rd", 32'(dout[0]), 32'hA);
    end
    // random traffic, including occasional clears
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 15)), 4'($urandom));
    end
    measure(n0, n1);
    // 6. reset mid-clear
    step(1, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 4'h0);
    rst_n = 1'b0;
    step(0, 0, 0, 4'h0, 4'h0);
    step(0, 0, 0, 4'h0, 4'h0);
    rst_n = 1'b1;
    measure(n0, n1);
    chk("mid_cycles12", 32'(n0), 32'd12);
    chk("mid_cycles16", 32'(n1), 32'd16);
    for (int a = 0; a < 16; a++) begin
      step(0, 1, 0, 4'(a), 4'h0);
      chk("mid_rd16", 32'(dout[1]), 32'hA);
    end
    step(0, 0, 0, 4'h0, 4'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
- Parametrised single-port synchronous RAM. It is the next generation of the 4-bit scratch RAM in the CPU data path.
- Adds configurable width and depth, and a hardware clear sequencer that runs after reset and on request.
- Read data is registered, with a valid strobe, a busy flag and out-of-range address detection.
- Sits between the CPU core memory interface and the bus decoder.

Parameters:
DATA_W, 4, data word width in bits
ADDR_W, 12, address width in bits
DEPTH, 4096, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W
CLEAR_VAL, 0, DATA_W-bit value written to every word during a clear sequence

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  request a full-array clear; sampled only in READY
read  input  1  read request for addr
write  input  1  write request of in to addr
addr  input  ADDR_W  word address
in  input  DATA_W  write data
out  output  DATA_W  registered read data
out_valid  output  1  one-cycle strobe: out holds the data for the read sampled on the previous edge
busy  output  1  clear sequence in progress; read, write and clear are ignored while high
addr_err  output  1  one-cycle strobe: the previous accepted read or write had addr >= DEPTH

Behaviour:
- Reset is asynchronous, active-low.
- While rst_n = 0:
  - state = CLEAR, clr_ptr = 0
  - out = 0, out_valid = 0, addr_err = 0, busy = 1
  - memory contents are not guaranteed
- States: CLEAR and READY.
- CLEAR state:
  - On each rising edge: mem[clr_ptr] <= CLEAR_VAL, clr_ptr increments.
  - On the edge that writes clr_ptr = DEPTH-1: clr_ptr <= 0, state <= READY, busy <= 0.
  - The clear therefore takes exactly DEPTH cycles after rst_n deasserts.
  - The first clear write happens on the first rising edge with rst_n = 1.
  - read, write and clear are ignored. out stays 0, out_valid = 0, addr_err = 0.
- READY state, priority per edge: clear > (read, write).
  - clear = 1:
    - state <= CLEAR, busy <= 1 on that edge.
    - Any read or write in the same cycle is dropped: no memory change, no out_valid.
  - write = 1, addr < DEPTH: mem[addr] <= in.
  - read = 1, addr < DEPTH: out <= mem[addr] (the value before any same-cycle write), out_valid <= 1.
  - Read latency is 1 cycle.
  - read and write to the same address in the same cycle: out returns the old data; the memory takes the new data.
  - read = 0: out <= 0 and out_valid <= 0. out is 0 whenever out_valid is 0.
  - Out-of-range access (addr >= DEPTH) with read or write high:
    - No memory change.
    - For a read: out <= 0 and out_valid <= 1.
    - addr_err <= 1 for one cycle.
  - In-range accesses and idle cycles: addr_err <= 0.
- Back-to-back reads give one result per cycle with no bubbles.
- Reset asserted mid-clear: the clear aborts immediately. After rst_n rises, the clear restarts from address 0 and runs the full DEPTH cycles.
- Reset mid-read: out and out_valid go to 0 asynchronously.
- clr_ptr wrap: the pointer never exceeds DEPTH-1. When DEPTH = 2**ADDR_W, the natural ADDR_W-bit wrap to 0 coincides with the exit from CLEAR.
- DEPTH = 1: CLEAR lasts 1 cycle, and every addr other than 0 is out of range.

Test Plan:
All scenarios use DATA_W=4, ADDR_W=4, DEPTH=12, CLEAR_VAL=4'hA unless stated otherwise.
1. Reset release:
   - Stimulus: hold rst_n=0 for 3 cycles, then release.
   - Required: busy=1 for exactly 12 rising edges, then 0.
   - Then read each of addresses 0..11: each returns 4'hA with out_valid one cycle after the request.
2. Write/read latency:
   - Stimulus: write 4'h5 to addr 3, then read addr 3 on the next cycle.
   - Required: out=4'h5 and out_valid=1 exactly one cycle after the read. On the following idle cycle, out=0 and out_valid=0.
3. Simultaneous read+write:
   - Stimulus: mem[7]=4'h2; drive read=1, write=1, addr=7, in=4'h9.
   - Required: out=4'h2 on the next cycle; a second read of addr 7 returns 4'h9.
4. Out of range:
   - Stimulus: write 4'hF to addr 13, then read addr 13.
   - Required: addr_err pulses after each access; the read returns out=0 with out_valid=1; addr 1 (13 mod 12) still reads 4'hA.
5. Clear request with colliding write:
   - Stimulus: in READY, assert clear=1 together with write to addr 0 (in=4'h3).
   - Required: the write is dropped; busy=1 for 12 cycles; every address reads 4'hA afterwards.
6. Reset mid-clear, full power-of-two depth (DEPTH=16):
   - Stimulus: assert rst_n=0 at clear cycle 5, release after 2 cycles.
   - Required: busy stays high for a full 16 cycles after release, and all addresses read 4'hA.
